// File: rtl/ddr_psi_pkg.sv
// Shared constants, descriptor layout and scheduler state encoding for the
// periodic PSI/SI DDR3 read-request initiator.
package ddr_psi_pkg;

  localparam int unsigned DESC_W   = 36;
  localparam int unsigned ADDR_W   = 28;
  localparam int unsigned LEN_W    = 8;
  localparam int unsigned LEN_MSB  = 35;
  localparam int unsigned LEN_LSB  = 28;
  localparam int unsigned ADDR_MSB = 27;

  // Descriptor as consumed by ddr_addr_treat: len in the top byte, addr below.
  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] addr;
  } psi_desc_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } sched_state_e;

endpackage

// File: rtl/ddr_psi_tick_gen.sv
// Period prescaler: tick is high for one cycle every TICK_DIV clocks.
module ddr_psi_tick_gen #(
  parameter int unsigned TICK_DIV = 27000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  // tick is registered one count early so it is high exactly while cnt == TICK_DIV-1
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      if (cnt == CNT_W'(TICK_DIV - 1)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      tick <= (cnt == CNT_W'(TICK_DIV - 2));
    end
  end

endmodule

// File: rtl/ddr_psi_rd_sched.sv
// Periodic PSI/SI read-descriptor scheduler: per-entry countdowns raise pend
// bits on ticks, a round-robin scan issues one descriptor per pending entry.
module ddr_psi_rd_sched
  import ddr_psi_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned IDX_W       = 3,
  parameter int unsigned TICK_DIV    = 27000,
  parameter int unsigned PERIOD_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_wr,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [27:0]         cfg_addr,
  input  logic [7:0]          cfg_len,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                cfg_en,
  input  logic                addr_full,
  output logic [35:0]         psi_addr_dout,
  output logic                psi_addr_dout_en,
  output logic [15:0]         missed_cnt,
  output logic                busy
);

  logic [ADDR_W-1:0]   tbl_addr   [NUM_ENTRIES];
  logic [LEN_W-1:0]    tbl_len    [NUM_ENTRIES];
  logic [PERIOD_W-1:0] tbl_period [NUM_ENTRIES];
  logic [PERIOD_W-1:0] tbl_cnt    [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] tbl_en;
  logic [NUM_ENTRIES-1:0] pend;
  logic [IDX_W-1:0]       ptr;
  sched_state_e           state;

  logic                   tick;
  logic [NUM_ENTRIES-1:0] cfg_v, set_v, clr_v, miss_v, pend_nxt;
  logic [PERIOD_W-1:0]    cfg_period_eff;
  logic                   cur_pend, cur_len_nz, cfg_hit_ptr;
  logic                   scan_clr, scan_adv, issue;
  psi_desc_t              desc;

  ddr_psi_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Scan decision and per-entry pend update; cfg beats tick, tick beats issue clear
  always_comb begin
    cfg_period_eff = (cfg_period == '0) ? PERIOD_W'(1) : cfg_period;
    cur_pend       = pend[ptr];
    cur_len_nz     = (tbl_len[ptr] != '0);
    cfg_hit_ptr    = cfg_wr && (cfg_idx == ptr);
    scan_clr       = (state == ST_SCAN) && cur_pend && (!cur_len_nz || !addr_full);
    scan_adv       = (state == ST_SCAN) && (!cur_pend || scan_clr);
    issue          = scan_clr && cur_len_nz && !cfg_hit_ptr;
    desc.len       = tbl_len[ptr];
    desc.addr      = tbl_addr[ptr];
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      cfg_v[i]    = cfg_wr && (cfg_idx == IDX_W'(i));
      set_v[i]    = tick && tbl_en[i] && (tbl_cnt[i] == PERIOD_W'(1)) && !cfg_v[i];
      clr_v[i]    = scan_clr && (ptr == IDX_W'(i));
      miss_v[i]   = set_v[i] && pend[i] && !clr_v[i];
      pend_nxt[i] = ((pend[i] && !clr_v[i]) || set_v[i]) && !cfg_v[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        tbl_addr[i]   <= '0;
        tbl_len[i]    <= '0;
        tbl_period[i] <= '0;
        tbl_cnt[i]    <= '0;
      end
      tbl_en           <= '0;
      pend             <= '0;
      ptr              <= '0;
      state            <= ST_IDLE;
      psi_addr_dout    <= '0;
      psi_addr_dout_en <= 1'b0;
      missed_cnt       <= '0;
      busy             <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (cfg_v[i]) begin
          tbl_addr[i]   <= cfg_addr;
          tbl_len[i]    <= cfg_len;
          tbl_period[i] <= cfg_period_eff;
          tbl_en[i]     <= cfg_en;
          tbl_cnt[i]    <= cfg_period_eff;
        end else if (tick && tbl_en[i]) begin
          tbl_cnt[i] <= (tbl_cnt[i] == PERIOD_W'(1)) ? tbl_period[i]
                                                     : tbl_cnt[i] - PERIOD_W'(1);
        end
      end
      pend <= pend_nxt;
      if (scan_adv) begin
        ptr <= ptr + IDX_W'(1);
      end
      state            <= (|pend_nxt) ? ST_SCAN : ST_IDLE;
      busy             <= |pend_nxt;
      psi_addr_dout_en <= issue;
      if (issue) begin
        psi_addr_dout <= desc;
      end
      if ((|miss_v) && (missed_cnt != 16'hFFFF)) begin
        missed_cnt <= missed_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ddr_psi_rd_sched.sv
// Directed bench for ddr_psi_rd_sched with a short prescaler (TICK_DIV=10).
`timescale 1ns/1ps
module tb_ddr_psi_rd_sched;

  localparam int unsigned NUM_ENTRIES = 8;
  localparam int unsigned IDX_W       = 3;
  localparam int unsigned TICK_DIV    = 10;
  localparam int unsigned PERIOD_W    = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                cfg_wr = 1'b0;
  logic [IDX_W-1:0]    cfg_idx = '0;
  logic [27:0]         cfg_addr = '0;
  logic [7:0]          cfg_len = '0;
  logic [PERIOD_W-1:0] cfg_period = '0;
  logic                cfg_en = 1'b0;
  logic                addr_full = 1'b0;
  logic [35:0]         psi_addr_dout;
  logic                psi_addr_dout_en;
  logic [15:0]         missed_cnt;
  logic                busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int base    = 0;

  logic [35:0] desc_q[$];
  int          desc_cyc_q[$];

  always #5 clk = ~clk;

  ddr_psi_rd_sched #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .IDX_W       (IDX_W),
    .TICK_DIV    (TICK_DIV),
    .PERIOD_W    (PERIOD_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_wr           (cfg_wr),
    .cfg_idx          (cfg_idx),
    .cfg_addr         (cfg_addr),
    .cfg_len          (cfg_len),
    .cfg_period       (cfg_period),
    .cfg_en           (cfg_en),
    .addr_full        (addr_full),
    .psi_addr_dout    (psi_addr_dout),
    .psi_addr_dout_en (psi_addr_dout_en),
    .missed_cnt       (missed_cnt),
    .busy             (busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every descriptor with the cycle it appeared in
  always @(negedge clk) begin
    if (psi_addr_dout_en === 1'b1) begin
      desc_q.push_back(psi_addr_dout);
      desc_cyc_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    cfg_wr    = 1'b0;
    addr_full = 1'b0;
    step(2);
    rst = 1'b0;
    desc_q.delete();
    desc_cyc_q.delete();
  endtask

  task automatic cfg(input int idx, input logic [27:0] addr, input logic [7:0] len,
                     input logic [15:0] period, input logic en);
    cfg_wr     = 1'b1;
    cfg_idx    = IDX_W'(idx);
    cfg_addr   = addr;
    cfg_len    = len;
    cfg_period = period;
    cfg_en     = en;
    step(1);
    cfg_wr = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_dout", 64'(psi_addr_dout), 64'h0);
    chk("rst_en", 64'(psi_addr_dout_en), 64'h0);
    chk("rst_missed", 64'(missed_cnt), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);

    // 1: single entry, period 3 ticks
    base = cyc;
    cfg(0, 28'h0001000, 8'd4, 16'd3, 1'b1);
    while (desc_q.size() < 3 && cyc < base + 200) step(1);
    chk("t1_count", 64'(desc_q.size()), 64'd3);
    if (desc_q.size() >= 3) begin
      chk("t1_lat", 64'(desc_cyc_q[0] - base), 64'd31);
      chk("t1_val0", 64'(desc_q[0]), 64'h040001000);
      chk("t1_val2", 64'(desc_q[2]), 64'h040001000);
      chk("t1_period", 64'(desc_cyc_q[2] - desc_cyc_q[1]), 64'd30);
    end

    // 2: eight entries, period 1, issued back to back in index order
    do_reset();
    base = cyc;
    for (int i = 0; i < 8; i++) cfg(i, 28'(i), 8'd1, 16'd1, 1'b1);
    goto(base + 20);
    chk("t2_count", 64'(desc_q.size()), 64'd8);
    if (desc_q.size() >= 8) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("t2_val%0d", i), 64'(desc_q[i]), {28'h0, 8'd1, 28'(i)});
        chk($sformatf("t2_cyc%0d", i), 64'(desc_cyc_q[i] - base), 64'(11 + i));
      end
    end
    goto(base + 45);
    chk("t2_missed", 64'(missed_cnt), 64'h0);

    // 3: backpressure across three ticks, then one descriptor on release
    do_reset();
    addr_full = 1'b1;
    base = cyc;
    cfg(2, 28'h22, 8'd2, 16'd1, 1'b1);
    goto(base + 29);
    chk("t3_missed1", 64'(missed_cnt), 64'd1);
    goto(base + 30);
    chk("t3_missed2", 64'(missed_cnt), 64'd2);
    chk("t3_none", 64'(desc_q.size()), 64'd0);
    addr_full = 1'b0;
    goto(base + 38);
    chk("t3_count", 64'(desc_q.size()), 64'd1);
    if (desc_q.size() >= 1) begin
      chk("t3_val", 64'(desc_q[0]), 64'h020000022);
      chk("t3_cyc", 64'(desc_cyc_q[0] - base), 64'd31);
    end
    chk("t3_missed_hold", 64'(missed_cnt), 64'd2);

    // 4: zero-length entry clears silently
    do_reset();
    base = cyc;
    cfg(4, 28'h44, 8'd0, 16'd1, 1'b1);
    goto(base + 10);
    chk("t4_busy_set", 64'(busy), 64'd1);
    goto(base + 15);
    chk("t4_busy_clr", 64'(busy), 64'd0);
    goto(base + 18);
    chk("t4_none", 64'(desc_q.size()), 64'd0);

    // 5: reset while entries 1 and 5 are pending
    do_reset();
    addr_full = 1'b1;
    base = cyc;
    cfg(1, 28'h11, 8'd1, 16'd1, 1'b1);
    cfg(5, 28'h55, 8'd1, 16'd1, 1'b1);
    goto(base + 10);
    chk("t5_busy", 64'(busy), 64'd1);
    goto(base + 20);
    chk("t5_missed", 64'(missed_cnt), 64'd1);
    addr_full = 1'b0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t5_en", 64'(psi_addr_dout_en), 64'd0);
    chk("t5_dout", 64'(psi_addr_dout), 64'h0);
    chk("t5_missed_rst", 64'(missed_cnt), 64'd0);
    chk("t5_busy_rst", 64'(busy), 64'd0);
    step(30);
    chk("t5_none", 64'(desc_q.size()), 64'd0);

    // 6: reprogramming entry 3 in its issue cycle suppresses the descriptor
    do_reset();
    addr_full = 1'b1;
    base = cyc;
    cfg(3, 28'h33, 8'd1, 16'd2, 1'b1);
    goto(base + 25);
    addr_full = 1'b0;
    cfg(3, 28'h44, 8'd1, 16'd2, 1'b1);
    chk("t6_busy", 64'(busy), 64'd0);
    goto(base + 38);
    chk("t6_none", 64'(desc_q.size()), 64'd0);
    goto(base + 50);
    chk("t6_count", 64'(desc_q.size()), 64'd1);
    if (desc_q.size() >= 1) begin
      chk("t6_val", 64'(desc_q[0]), 64'h010000044);
      chk("t6_cyc", 64'(desc_cyc_q[0] - base), 64'd48);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
